// File: rtl/guess_entry_buffer.sv
// Digit-entry shift buffer: collects hex digits, supports delete/submit and
// hands the finished guess downstream over valid/ready. Option: GUESS_AUTO_SUBMIT_EN.
module guess_entry_buffer #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            hex,
  input  logic                  pulse,
  input  logic                  del,
  input  logic                  submit,
  input  logic                  guess_ready,
  output logic [4*DIGITS-1:0]   guess,
  output logic                  guess_valid,
  output logic [CNT_W-1:0]      digit_cnt,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  err
);

  // Handshake: guess_valid rises only in HOLD and stays high with guess frozen
  // until a cycle where guess_valid && guess_ready; the transfer happens then.
  typedef enum logic [1:0] {ENTRY = 2'd0, FULL = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] DIG_C = CNT_W'(DIGITS);

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [4*DIGITS+3:0]   shl;
  logic [CNT_W-1:0]      cnt_inc;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    shl     = {buf_q, hex};
    cnt_inc = cnt_q + 1'b1;
    if (state_q == HOLD) begin
      if (valid_q && guess_ready) begin
        buf_d   = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        state_d = ENTRY;
      end
    end else if (submit) begin
`ifndef GUESS_AUTO_SUBMIT_EN
      if (state_q == FULL) begin
        state_d = HOLD;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
`endif
    end else if (del) begin
      if (cnt_q != '0) begin
        buf_d   = buf_q >> 4;
        cnt_d   = cnt_q - 1'b1;
        state_d = ENTRY;
      end else begin
        err_d = 1'b1;
      end
    end else if (pulse) begin
      if (state_q == ENTRY) begin
        buf_d = shl[4*DIGITS-1:0];
        cnt_d = cnt_inc;
        if (cnt_inc == DIG_C) begin
`ifdef GUESS_AUTO_SUBMIT_EN
          state_d = HOLD;
          valid_d = 1'b1;
`else
          state_d = FULL;
`endif
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign guess       = buf_q;
  assign disp        = buf_q;
  assign digit_cnt   = cnt_q;
  assign guess_valid = valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_guess_entry_buffer.sv
// Self-checking bench for guess_entry_buffer (DIGITS=4): behavioural model
// feeds an expected queue, plus fixed-value checks from the scenario list.
module tb_guess_entry_buffer;

  localparam int DIGITS = 4;
  localparam int CNT_W  = 4;
  localparam int W      = 4*DIGITS + 1 + CNT_W + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [3:0]          hex = 4'h0;
  logic                pulse = 1'b0, del = 1'b0, submit = 1'b0, guess_ready = 1'b0;
  logic [4*DIGITS-1:0] guess, disp;
  logic                guess_valid, err;
  logic [CNT_W-1:0]    digit_cnt;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // model state: 0 ENTRY, 1 FULL, 2 HOLD
  int                  m_st = 0;
  logic [4*DIGITS-1:0] m_buf = '0;
  logic [CNT_W-1:0]    m_cnt = '0;
  logic                m_valid = 1'b0, m_err = 1'b0;

  guess_entry_buffer #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hex(hex), .pulse(pulse), .del(del), .submit(submit),
    .guess_ready(guess_ready), .guess(guess), .guess_valid(guess_valid),
    .digit_cnt(digit_cnt), .disp(disp), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model(input logic p, input logic [3:0] h, input logic d,
                       input logic s, input logic r, input logic rs);
    m_err = 1'b0;
    if (rs) begin
      m_st = 0; m_buf = '0; m_cnt = '0; m_valid = 1'b0;
    end else if (m_st == 2) begin
      if (r) begin
        m_st = 0; m_buf = '0; m_cnt = '0; m_valid = 1'b0;
      end
    end else if (s) begin
`ifndef GUESS_AUTO_SUBMIT_EN
      if (m_st == 1) begin m_st = 2; m_valid = 1'b1; end
      else m_err = 1'b1;
`endif
    end else if (d) begin
      if (m_cnt == 0) m_err = 1'b1;
      else begin m_buf = m_buf >> 4; m_cnt = m_cnt - 1; m_st = 0; end
    end else if (p) begin
      if (m_st == 1) m_err = 1'b1;
      else begin
        m_buf = (m_buf << 4) | {{(4*DIGITS-4){1'b0}}, h};
        m_cnt = m_cnt + 1;
        if (m_cnt == DIGITS) begin
`ifdef GUESS_AUTO_SUBMIT_EN
          m_st = 2; m_valid = 1'b1;
`else
          m_st = 1;
`endif
        end
      end
    end
  endtask

  // One clock: drive strobes, predict, then compare the registered outputs.
  task automatic step(input logic p, input logic [3:0] h, input logic d,
                      input logic s, input logic r, input logic rs);
    logic [W-1:0] exp_v, act_v;
    @(negedge clk);
    pulse = p; hex = h; del = d; submit = s; guess_ready = r; rst = rs;
    model(p, h, d, s, r, rs);
    exp_q.push_back({m_buf, m_valid, m_cnt, m_err});
    @(posedge clk);
    #1;
    pulse = 1'b0; del = 1'b0; submit = 1'b0; guess_ready = 1'b0; rst = 1'b0;
    exp_v = exp_q.pop_front();
    act_v = {guess, guess_valid, digit_cnt, err};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL scoreboard t=%0t guess/valid/cnt/err got %h/%b/%0d/%b want %h/%b/%0d/%b",
               $time, guess, guess_valid, digit_cnt, err,
               exp_v[W-1 -: 4*DIGITS], exp_v[CNT_W+1], exp_v[CNT_W:1], exp_v[0]);
    end
    checks++;
    if (disp !== guess) begin
      errors++;
      $display("FAIL disp_eq_guess got %h want %h", disp, guess);
    end
  endtask

  task automatic idle();     step(0, 4'h0, 0, 0, 0, 0); endtask
  task automatic dig(input logic [3:0] h); step(1, h, 0, 0, 0, 0); endtask
  task automatic do_reset(); step(0, 4'h0, 0, 0, 0, 1); endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({guess, guess_valid, digit_cnt, err} !== '0) begin
      errors++;
      $display("FAIL reset_state got guess=%h valid=%b cnt=%0d err=%b want all 0",
               guess, guess_valid, digit_cnt, err);
    end
  endtask

`ifndef GUESS_AUTO_SUBMIT_EN
  task automatic test_entry();
    do_reset();
    dig(4'h3); dig(4'h5); dig(4'h1); dig(4'h7);
    checks++;
    if (guess !== 16'h3517 || digit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL entry_3517 got %h cnt %0d want 3517 cnt 4", guess, digit_cnt);
    end
  endtask

  task automatic test_full_err_del();
    dig(4'h2);
    checks++;
    if (err !== 1'b1 || guess !== 16'h3517) begin
      errors++;
      $display("FAIL full_pulse_err got err=%b guess=%h want 1 3517", err, guess);
    end
    step(0, 4'h0, 1, 0, 0, 0);
    checks++;
    if (guess !== 16'h0351 || digit_cnt !== 4'd3 || err !== 1'b0) begin
      errors++;
      $display("FAIL del_from_full got %h cnt %0d err %b want 0351 cnt 3 err 0",
               guess, digit_cnt, err);
    end
  endtask

  task automatic test_incomplete_submit();
    do_reset();
    dig(4'h4); dig(4'h2);
    step(0, 4'h0, 0, 1, 0, 0);
    checks++;
    if (err !== 1'b1 || guess_valid !== 1'b0 || guess !== 16'h0042) begin
      errors++;
      $display("FAIL submit_incomplete got err=%b valid=%b guess=%h want 1 0 0042",
               err, guess_valid, guess);
    end
    dig(4'h1);
    step(1, 4'h9, 0, 1, 0, 0);
    checks++;
    if (err !== 1'b1 || digit_cnt !== 4'd3 || guess !== 16'h0421) begin
      errors++;
      $display("FAIL submit_over_pulse got err=%b cnt=%0d guess=%h want 1 3 0421",
               err, digit_cnt, guess);
    end
    step(0, 4'h0, 1, 0, 0, 1'b0);
    step(0, 4'h0, 1, 0, 0, 1'b0);
    step(0, 4'h0, 1, 0, 0, 1'b0);
    step(0, 4'h0, 1, 0, 0, 1'b0);
    checks++;
    if (err !== 1'b1 || digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL del_empty got err=%b cnt=%0d want 1 0", err, digit_cnt);
    end
  endtask

  task automatic test_hold();
    do_reset();
    dig(4'h3); dig(4'h5); dig(4'h1); dig(4'h7);
    step(0, 4'h0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(i[0], 4'hA, ~i[0], i == 2, 0, 0);
    checks++;
    if (guess_valid !== 1'b1 || guess !== 16'h3517 || err !== 1'b0) begin
      errors++;
      $display("FAIL hold_stable got valid=%b guess=%h err=%b want 1 3517 0",
               guess_valid, guess, err);
    end
    step(0, 4'h0, 0, 0, 1, 0);
    checks++;
    if (guess_valid !== 1'b0 || guess !== 16'h0 || digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL hold_accept got valid=%b guess=%h cnt=%0d want 0 0000 0",
               guess_valid, guess, digit_cnt);
    end
  endtask

  task automatic test_reset_in_hold();
    dig(4'h3); dig(4'h5); dig(4'h1); dig(4'h7);
    step(0, 4'h0, 0, 1, 0, 0);
    idle();
    step(0, 4'h0, 0, 0, 1, 1);
    checks++;
    if ({guess, guess_valid, digit_cnt, err} !== '0) begin
      errors++;
      $display("FAIL reset_in_hold got guess=%h valid=%b cnt=%0d want all 0",
               guess, guess_valid, digit_cnt);
    end
    dig(4'h6);
    checks++;
    if (guess !== 16'h0006 || digit_cnt !== 4'd1) begin
      errors++;
      $display("FAIL after_reset_pulse got %h cnt %0d want 0006 cnt 1", guess, digit_cnt);
    end
  endtask
`else
  task automatic test_auto();
    do_reset();
    dig(4'h1); dig(4'h2); dig(4'h3); dig(4'h4);
    checks++;
    if (guess_valid !== 1'b1 || guess !== 16'h1234) begin
      errors++;
      $display("FAIL auto_submit got valid=%b guess=%h want 1 1234", guess_valid, guess);
    end
    step(0, 4'h0, 0, 1, 1, 0);
    checks++;
    if (guess_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL auto_accept got valid=%b err=%b want 0 0", guess_valid, err);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 50, 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2);
    end
  endtask

  initial begin
    test_reset();
`ifndef GUESS_AUTO_SUBMIT_EN
    test_entry();
    test_full_err_del();
    test_incomplete_submit();
    test_hold();
    test_reset_in_hold();
`else
    test_auto();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
